// File: rtl/cnn_pkg.sv
// Shared widths, data types and arbiter state encoding for the CNN block loaders.
package cnn_pkg;
  localparam int MEM_ADDR_SIZE = 16;
  localparam int DATA_SIZE     = 16;
  localparam int BLOCK_SIZE    = 25;

  typedef logic signed [DATA_SIZE-1:0] word_t;
  typedef word_t block_t [0:BLOCK_SIZE-1];

  typedef enum logic [1:0] {IDLE, ISSUE, LAST, FIN} arb_state_t;
endpackage

// File: rtl/dma_block_arbiter_rr.sv
// Combinational round-robin pick: first set request at or after the pointer, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   pointer,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   index
);
  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((int'(pointer) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        grant[cand] = 1'b1;
        index       = cand;
        found       = 1'b1;
      end
    end
  end
endmodule

// File: rtl/dma_block_arbiter.sv
// Shares the DMA read port among block loaders; each granted burst is issued as BLOCK_SIZE-word reads.
//  state | meaning
//  IDLE  | no burst; arbitrate and latch the winner's burst
//  ISSUE | one read per cycle until nblk reads are out
//  LAST  | no read; final block returning from memory
//  FIN   | done pulse to owner, pointer moves past owner
module dma_block_arbiter
  import cnn_pkg::*;
#(
  parameter int NUM_REQ   = 3,
  parameter int LEN_WIDTH = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ*MEM_ADDR_SIZE-1:0] req_addr,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]     req_len,
  output logic [NUM_REQ-1:0]               grant,
  output logic                             busy,
  output logic [MEM_ADDR_SIZE-1:0]         dmaAddr,
  output logic                             dmaRd,
  input  block_t                           dmaOut,
  output logic                             blk_valid,
  output block_t                           blk_data,
  output logic [$clog2(NUM_REQ)-1:0]       blk_owner,
  output logic [LEN_WIDTH-1:0]             blk_index,
  output logic [NUM_REQ-1:0]               done
);
  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t               state, state_nxt;
  logic [NUM_REQ-1:0]       arb_grant;
  logic [IDX_W-1:0]         arb_idx;
  logic [IDX_W-1:0]         ptr_r, owner_r;
  logic [NUM_REQ-1:0]       owner_hot_r;
  logic [MEM_ADDR_SIZE-1:0] addr_r, sel_addr;
  logic [LEN_WIDTH-1:0]     sel_len;
  logic [LEN_WIDTH:0]       sel_nblk, nblk_r, n_r;
  logic                     rd_d;
  logic [LEN_WIDTH-1:0]     idx_d;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req     (req),
    .pointer (ptr_r),
    .grant   (arb_grant),
    .index   (arb_idx)
  );

  assign sel_addr = req_addr[arb_idx*MEM_ADDR_SIZE +: MEM_ADDR_SIZE];
  assign sel_len  = req_len[arb_idx*LEN_WIDTH +: LEN_WIDTH];
  // One extra bit so the rounding add cannot overflow for the largest length.
  assign sel_nblk = ({1'b0, sel_len} + (LEN_WIDTH+1)'(BLOCK_SIZE-1)) / (LEN_WIDTH+1)'(BLOCK_SIZE);
  assign blk_owner = owner_r;

  always_comb begin
    state_nxt = state;
    grant     = '0;
    busy      = 1'b0;
    dmaRd     = 1'b0;
    dmaAddr   = '0;
    done      = '0;
    case (state)
      IDLE: begin
        if (|req) state_nxt = (sel_len == '0) ? FIN : ISSUE;
      end
      ISSUE: begin
        busy    = 1'b1;
        grant   = owner_hot_r;
        dmaRd   = 1'b1;
        dmaAddr = addr_r;
        if (n_r == nblk_r - (LEN_WIDTH+1)'(1)) state_nxt = LAST;
      end
      LAST: begin
        busy      = 1'b1;
        grant     = owner_hot_r;
        state_nxt = FIN;
      end
      FIN: begin
        busy      = 1'b1;
        grant     = owner_hot_r;
        done      = owner_hot_r;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ptr_r       <= '0;
      owner_r     <= '0;
      owner_hot_r <= '0;
      addr_r      <= '0;
      nblk_r      <= '0;
      n_r         <= '0;
      rd_d        <= 1'b0;
      idx_d       <= '0;
      blk_valid   <= 1'b0;
      blk_index   <= '0;
      blk_data    <= '{default: '0};
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (|req) begin
            owner_r     <= arb_idx;
            owner_hot_r <= arb_grant;
            addr_r      <= sel_addr;
            nblk_r      <= sel_nblk;
            n_r         <= '0;
          end
        end
        ISSUE: begin
          n_r    <= n_r + (LEN_WIDTH+1)'(1);
          addr_r <= addr_r + MEM_ADDR_SIZE'(BLOCK_SIZE);
        end
        FIN: ptr_r <= (owner_r == IDX_W'(NUM_REQ-1)) ? '0 : owner_r + IDX_W'(1);
        default: ;
      endcase

      // Memory answers the cycle after the strobe; capture it at the end of that cycle.
      rd_d <= dmaRd;
      if (dmaRd) idx_d <= n_r[LEN_WIDTH-1:0];
      blk_valid <= rd_d;
      if (rd_d) begin
        blk_data  <= dmaOut;
        blk_index <= idx_d;
      end
    end
  end
endmodule

// File: tb/tb_dma_block_arbiter.sv
// Directed bench for dma_block_arbiter: single-burst vector table plus round-robin and reset sequences.
module tb_dma_block_arbiter;
  import cnn_pkg::*;

  localparam int NR = 3;
  localparam int LW = 16;

  logic                        clk = 1'b0;
  logic                        reset = 1'b1;
  logic [NR-1:0]               req = '0;
  logic [NR*MEM_ADDR_SIZE-1:0] req_addr = '0;
  logic [NR*LW-1:0]            req_len = '0;
  logic [NR-1:0]               grant, done;
  logic                        busy, dmaRd, blk_valid;
  logic [MEM_ADDR_SIZE-1:0]    dmaAddr;
  block_t                      dmaOut, blk_data;
  logic [1:0]                  blk_owner;
  logic [LW-1:0]               blk_index;
  logic [15:0]                 mem_q = '0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dma_block_arbiter #(.NUM_REQ(NR), .LEN_WIDTH(LW)) dut (
    .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .req_len(req_len),
    .grant(grant), .busy(busy), .dmaAddr(dmaAddr), .dmaRd(dmaRd), .dmaOut(dmaOut),
    .blk_valid(blk_valid), .blk_data(blk_data), .blk_owner(blk_owner),
    .blk_index(blk_index), .done(done)
  );

  function automatic logic [15:0] mdl(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  // Memory model: data for the strobed address appears the following cycle.
  always @(posedge clk) if (dmaRd) mem_q <= dmaAddr;
  always_comb begin
    for (int j = 0; j < BLOCK_SIZE; j++) dmaOut[j] = word_t'(mdl(mem_q + 16'(j)));
  end

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          who;
    logic [15:0] addr;
    logic [15:0] len;
    int          nblk;
    logic [15:0] a0;
    logic [15:0] a1;
    int          done_cyc;
  } vec_t;

  vec_t vt [7];

  initial begin
    int reads, first_rd, done_cyc, beats, ndone, found;
    bit idx_ok, data_ok, grant_ok, owner_ok, excl_ok, early_done;
    logic [15:0] a0, a1, ba;
    logic [NR-1:0] done_val, hot;
    int order [4];
    int dcyc [4];

    vt[0] = '{0, 16'h0100, 16'd50, 2, 16'h0100, 16'h0119, 5};
    vt[1] = '{1, 16'h0200, 16'd26, 2, 16'h0200, 16'h0219, 5};
    vt[2] = '{0, 16'hFFF0, 16'd50, 2, 16'hFFF0, 16'h0009, 5};
    vt[3] = '{1, 16'h0040, 16'd25, 1, 16'h0040, 16'h0000, 4};
    vt[4] = '{2, 16'h1000, 16'd75, 3, 16'h1000, 16'h1019, 6};
    vt[5] = '{0, 16'h0010, 16'd1,  1, 16'h0010, 16'h0000, 4};
    vt[6] = '{2, 16'h0300, 16'd0,  0, 16'h0000, 16'h0000, 2};

    repeat (3) @(posedge clk);
    #1;
    req = 3'b111;
    @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dmaRd", dmaRd, 0);
    chk("rst_done", done, 0);
    chk("rst_blk_valid", blk_valid, 0);
    chk("rst_dmaAddr", dmaAddr, 0);
    req = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int v = 0; v < 7; v++) begin
      req_addr = '0;
      req_len  = '0;
      req_addr[vt[v].who*16 +: 16] = vt[v].addr;
      req_len[vt[v].who*16 +: 16]  = vt[v].len;
      hot = NR'(1) << vt[v].who;
      req = hot;
      reads = 0; first_rd = 0; done_cyc = 0; beats = 0; a0 = '0; a1 = '0; done_val = '0;
      idx_ok = 1; data_ok = 1; grant_ok = 1; owner_ok = 1;
      for (int c = 1; c <= 20 && done_cyc == 0; c++) begin
        @(negedge clk);
        if (dmaRd) begin
          if (reads == 0) begin a0 = dmaAddr; first_rd = c; end
          else if (reads == 1) a1 = dmaAddr;
          reads++;
        end
        if (blk_valid) begin
          if (blk_index !== LW'(beats)) idx_ok = 0;
          if (blk_owner !== 2'(vt[v].who)) owner_ok = 0;
          ba = vt[v].addr + 16'(beats * BLOCK_SIZE);
          for (int j = 0; j < BLOCK_SIZE; j++)
            if (blk_data[j] !== word_t'(mdl(ba + 16'(j)))) data_ok = 0;
          beats++;
        end
        if (busy ? (grant !== hot) : (grant !== '0)) grant_ok = 0;
        if (|done) begin done_cyc = c; done_val = done; end
        @(posedge clk);
        #1;
      end
      req = '0;
      chk($sformatf("v%0d_reads", v), reads, vt[v].nblk);
      chk($sformatf("v%0d_addr0", v), a0, vt[v].a0);
      chk($sformatf("v%0d_addr1", v), a1, vt[v].a1);
      chk($sformatf("v%0d_first_rd_cycle", v), first_rd, (vt[v].nblk > 0) ? 2 : 0);
      chk($sformatf("v%0d_done_cycle", v), done_cyc, vt[v].done_cyc);
      chk($sformatf("v%0d_done_val", v), done_val, hot);
      chk($sformatf("v%0d_beats", v), beats, vt[v].nblk);
      chk($sformatf("v%0d_blk_index", v), idx_ok, 1);
      chk($sformatf("v%0d_blk_data", v), data_ok, 1);
      chk($sformatf("v%0d_blk_owner", v), owner_ok, 1);
      chk($sformatf("v%0d_grant", v), grant_ok, 1);
      @(negedge clk);
      chk($sformatf("v%0d_idle_busy", v), busy, 0);
      @(posedge clk);
      #1;
    end

    // All three held high after the len-0 burst on requester 2: pointer back at 0.
    req_addr = {16'h3000, 16'h2000, 16'h1000};
    req_len  = {16'd25, 16'd25, 16'd25};
    req = 3'b111;
    ndone = 0; excl_ok = 1;
    for (int k = 0; k < 4; k++) begin order[k] = 9; dcyc[k] = 0; end
    for (int c = 1; c <= 40 && ndone < 4; c++) begin
      @(negedge clk);
      if ($countones(grant) > 1) excl_ok = 0;
      if (|done) begin
        order[ndone] = (done == 3'b001) ? 0 : (done == 3'b010) ? 1 : (done == 3'b100) ? 2 : 9;
        dcyc[ndone] = c;
        ndone++;
      end
      @(posedge clk);
      #1;
    end
    req = '0;
    chk("rr_ndone", ndone, 4);
    chk("rr_order0", order[0], 0);
    chk("rr_order1", order[1], 1);
    chk("rr_order2", order[2], 2);
    chk("rr_order3", order[3], 0);
    chk("rr_done_cyc0", dcyc[0], 4);
    chk("rr_done_cyc3", dcyc[3], 16);
    chk("rr_grant_exclusive", excl_ok, 1);
    @(posedge clk);
    #1;

    // Reset during block 3 of a 5-block burst, request held throughout.
    req_addr = '0;
    req_len  = '0;
    req_addr[16 +: 16] = 16'h2000;
    req_len[16 +: 16]  = 16'd125;
    req = 3'b010;
    found = 0; early_done = 0;
    for (int c = 1; c <= 20 && found == 0; c++) begin
      @(negedge clk);
      if (|done) early_done = 1;
      if (dmaRd && dmaAddr == 16'h204B) begin
        found = 1;
        reset = 1'b1;
      end
    end
    chk("mid_rst_reached_blk3", found, 1);
    chk("mid_rst_no_early_done", early_done, 0);
    @(negedge clk);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_grant", grant, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_dmaRd", dmaRd, 0);
    chk("mid_rst_blk_valid", blk_valid, 0);
    chk("mid_rst_blk_index", blk_index, 0);
    chk("mid_rst_blk_data0", blk_data[0], 0);
    reset = 1'b0;
    @(negedge clk);
    chk("regrant_dmaRd", dmaRd, 1);
    chk("regrant_addr", dmaAddr, 16'h2000);
    chk("regrant_grant", grant, 3'b010);
    reads = 1; done_val = '0;
    for (int c = 1; c <= 20 && done_val == '0; c++) begin
      @(negedge clk);
      if (dmaRd) reads++;
      if (|done) done_val = done;
    end
    req = '0;
    chk("regrant_reads", reads, 5);
    chk("regrant_done", done_val, 3'b010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
